// File: rtl/sb_prefetch_ctrl_pkg.sv
// Shared types for the stream-buffer prefetch controller: FSM state encoding,
// physical address type and the line-label width helper derived from it.
package sb_prefetch_ctrl_pkg;

    localparam int PHYS_WIDTH     = 32;
    localparam int SB_LINE_WIDTH  = 256;
    localparam int PERF_CNT_WIDTH = 32;

    typedef logic [PHYS_WIDTH-1:0] phys_t;

    // A label is the physical address with the byte-within-line offset removed.
    function automatic int sb_label_width(input int line_width);
        return $bits(phys_t) - $clog2(line_width / 8);
    endfunction

    localparam int SB_LABEL_WIDTH = sb_label_width(SB_LINE_WIDTH);

    typedef logic [SB_LABEL_WIDTH-1:0] sb_label_t;

    typedef enum logic [2:0] {
        SBC_IDLE,
        SBC_DRAIN,
        SBC_DISSUE,
        SBC_DWAIT,
        SBC_RESP,
        SBC_PISSUE
    } sbc_state_t;

endpackage

// File: rtl/sb_perf_cnt.sv
// Three saturating event counters (hit, miss, drain) for the prefetch controller.
module sb_perf_cnt
    import sb_prefetch_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      hit_inc,
    input  logic                      miss_inc,
    input  logic                      drain_inc,
    output logic [PERF_CNT_WIDTH-1:0] hit_cnt,
    output logic [PERF_CNT_WIDTH-1:0] miss_cnt,
    output logic [PERF_CNT_WIDTH-1:0] drain_cnt
);

    // Each counter sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            drain_cnt <= '0;
        end else begin
            if (hit_inc && (hit_cnt != '1))
                hit_cnt <= hit_cnt + 1'b1;
            if (miss_inc && (miss_cnt != '1))
                miss_cnt <= miss_cnt + 1'b1;
            if (drain_inc && (drain_cnt != '1))
                drain_cnt <= drain_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sb_prefetch_ctrl.sv
// Miss-path sequencer for one stream buffer: serves hits, demand-fetches misses
// and issues a next-line prefetch. Define SB_PERF_CNT_EN to add perf counters.
module sb_prefetch_ctrl
    import sb_prefetch_ctrl_pkg::*;
#(
    parameter int LINE_WIDTH    = SB_LINE_WIDTH,
    parameter int LABEL_WIDTH   = sb_label_width(SB_LINE_WIDTH),
    parameter bit PREFETCH_NEXT = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      miss_req,
    input  logic [LABEL_WIDTH-1:0]    miss_label,
    output logic                      resp_vld,
    output logic                      resp_hit,
    output logic [LINE_WIDTH-1:0]     resp_data,
    output logic [LABEL_WIDTH-1:0]    sb_label,
    output logic                      sb_label_rdy,
    input  logic [LABEL_WIDTH-1:0]    sb_label_o,
    input  logic [LINE_WIDTH-1:0]     sb_data,
    input  logic                      sb_data_vld,
`ifdef SB_PERF_CNT_EN
    output logic [PERF_CNT_WIDTH-1:0] perf_hit_cnt,
    output logic [PERF_CNT_WIDTH-1:0] perf_miss_cnt,
    output logic [PERF_CNT_WIDTH-1:0] perf_drain_cnt,
`endif
    output sbc_state_t                state_dbg
);

    // Handshake: sb_label_rdy is a single-cycle start pulse, only raised while
    // no fetch is outstanding; the buffer answers by raising sb_data_vld, which
    // is not trusted in the cycle right after the pulse (stale line still shown).

    sbc_state_t state_q, state_d;

    logic                   busy_q;
    logic                   guard_q;
    logic                   hit_q;
    logic [LABEL_WIDTH-1:0] req_label_q;
    logic [LABEL_WIDTH-1:0] inflight_label_q;
    logic [LINE_WIDTH-1:0]  data_q;

    logic                   data_ok;
    logic                   issue;
    logic [LABEL_WIDTH-1:0] issue_label;
    logic                   accept;
    logic                   latch_en;
    logic                   latch_hit;

    assign data_ok = sb_data_vld && !guard_q;

    always_comb begin
        state_d     = state_q;
        issue       = 1'b0;
        issue_label = '0;
        accept      = 1'b0;
        latch_en    = 1'b0;
        latch_hit   = 1'b0;
        unique case (state_q)
            SBC_IDLE: begin
                if (miss_req) begin
                    accept = 1'b1;
                    if (!busy_q && sb_data_vld && (sb_label_o == miss_label)) begin
                        state_d   = SBC_RESP;
                        latch_en  = 1'b1;
                        latch_hit = 1'b1;
                    end else if (busy_q && (inflight_label_q == miss_label)) begin
                        state_d = SBC_DWAIT;
                    end else if (busy_q) begin
                        state_d = SBC_DRAIN;
                    end else begin
                        state_d = SBC_DISSUE;
                    end
                end
            end
            // An unwanted prefetch cannot be aborted; let it land first.
            SBC_DRAIN: begin
                if (data_ok)
                    state_d = SBC_DISSUE;
            end
            SBC_DISSUE: begin
                issue       = 1'b1;
                issue_label = req_label_q;
                state_d     = SBC_DWAIT;
            end
            SBC_DWAIT: begin
                if (data_ok) begin
                    latch_en = 1'b1;
                    state_d  = SBC_RESP;
                end
            end
            SBC_RESP: begin
                state_d = PREFETCH_NEXT ? SBC_PISSUE : SBC_IDLE;
            end
            SBC_PISSUE: begin
                issue       = 1'b1;
                issue_label = req_label_q + 1'b1;
                state_d     = SBC_IDLE;
            end
            default: state_d = SBC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= SBC_IDLE;
            busy_q           <= 1'b0;
            guard_q          <= 1'b0;
            hit_q            <= 1'b0;
            req_label_q      <= '0;
            inflight_label_q <= '0;
            data_q           <= '0;
        end else begin
            state_q <= state_d;
            guard_q <= issue;
            if (issue) begin
                busy_q           <= 1'b1;
                inflight_label_q <= issue_label;
            end else if (data_ok) begin
                busy_q <= 1'b0;
            end
            if (accept)
                req_label_q <= miss_label;
            if (latch_en) begin
                data_q <= sb_data;
                hit_q  <= latch_hit;
            end
        end
    end

    assign resp_vld     = (state_q == SBC_RESP);
    assign resp_hit     = resp_vld && hit_q;
    assign resp_data    = data_q;
    assign sb_label     = issue_label;
    assign sb_label_rdy = issue;
    assign state_dbg    = state_q;

`ifdef SB_PERF_CNT_EN
    logic drain_entry;
    assign drain_entry = (state_q == SBC_IDLE) && (state_d == SBC_DRAIN);

    sb_perf_cnt u_perf_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .hit_inc   (resp_vld && hit_q),
        .miss_inc  (resp_vld && !hit_q),
        .drain_inc (drain_entry),
        .hit_cnt   (perf_hit_cnt),
        .miss_cnt  (perf_miss_cnt),
        .drain_cnt (perf_drain_cnt)
    );
`endif

    // The cache must hold its request steady until the response arrives.
    miss_held_a: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q inside {SBC_DRAIN, SBC_DISSUE, SBC_DWAIT})
            |-> (miss_req && (miss_label == req_label_q)));

endmodule

// File: doc/sb_prefetch_ctrl.md
Name: sb_prefetch_ctrl

Overview:
Sequencing controller for the stream-buffer prefetch engine. It sits between a cache miss path (icache or dcache refill) and one stream_buffer instance. Each miss is served either from the buffered line (hit) or by issuing a demand fetch through the buffer. After every served line it launches a next-line prefetch (label+1).

Parameters:
LINE_WIDTH, 256, cache line width in bits; must match the attached stream buffer.
LABEL_WIDTH, 27, line label width (tag+index) = bits of phys_t minus log2(LINE_WIDTH/8).
PREFETCH_NEXT, 1, 1 = issue label+1 prefetch after each response; 0 = demand-only.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
miss_req  in  1  cache requests a line; held high with stable miss_label until resp_vld
miss_label  in  LABEL_WIDTH  requested line label
resp_vld  out  1  one-cycle pulse: resp_data holds the requested line
resp_hit  out  1  qualifies resp_vld: 1 = served from an already-buffered line, 0 = demand fetch
resp_data  out  LINE_WIDTH  line data, registered
sb_label  out  LABEL_WIDTH  label driven to stream buffer label_i
sb_label_rdy  out  1  one-cycle start pulse to stream buffer label_i_rdy
sb_label_o  in  LABEL_WIDTH  label of buffered line
sb_data  in  LINE_WIDTH  buffered line
sb_data_vld  in  1  buffered line valid

Behaviour:
- Reset (async, rst_n=0): state=IDLE; resp_vld, resp_hit, sb_label_rdy, sb_label, resp_data, busy=0. The stream buffer is reset from the same source (rst = ~rst_n), so no in-flight fetch survives reset.
- The busy register is set on the cycle sb_label_rdy pulses. It clears in any later cycle where sb_data_vld=1.
- inflight_label register captures sb_label on each pulse.
- sb_label_rdy is only ever asserted when busy=0, one cycle wide. The cycle after a pulse, sb_data_vld is ignored (the buffer drops it then).
- States:
  IDLE:
  - miss_req && !busy && sb_data_vld && sb_label_o==miss_label -> RESP; latch sb_data; hit=1.
  - miss_req && busy && inflight_label==miss_label -> DWAIT (merge with prefetch; hit=0).
  - miss_req otherwise -> if busy, DRAIN; else DISSUE.
  DRAIN: wait for sb_data_vld (unwanted prefetch completes; it cannot be aborted) -> DISSUE.
  DISSUE: sb_label=miss_label, sb_label_rdy=1 -> DWAIT.
  DWAIT: first cycle after an issue is a guard cycle. Then on sb_data_vld: latch sb_data; hit=0 -> RESP.
  RESP: resp_vld=1 for exactly one cycle, resp_hit per latch -> PISSUE if PREFETCH_NEXT, else IDLE.
  PISSUE: sb_label=miss_label_latched+1 (modulo 2^LABEL_WIDTH; all-ones wraps to 0), sb_label_rdy=1 -> IDLE. No wait for completion.
- Latency: hit = miss_req to resp_vld in 1 cycle. Demand latency = 2 cycles + buffer fetch time.
- A miss_req arriving during RESP/PISSUE is sampled only in IDLE, so at most one extra cycle.
- miss_req dropping before resp_vld is illegal. It is flagged by an assertion and not handled.

Optional Feature:
SB_PERF_CNT_EN:
- Defined: adds outputs perf_hit_cnt, perf_miss_cnt, perf_drain_cnt (32-bit each, saturating, cleared by reset). They increment on RESP with hit=1, RESP with hit=0, and DRAIN entry respectively.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- The shared package gains a typedef enum sbc_state_t {SBC_IDLE, SBC_DRAIN, SBC_DISSUE, SBC_DWAIT, SBC_RESP, SBC_PISSUE} and an sb_label_t width helper derived from phys_t and LINE_WIDTH.
- One natural sub-module: sb_perf_cnt (three saturating counters), instantiated only under SB_PERF_CNT_EN.

Test Plan:
- Cold miss label 0x100, buffer idle/invalid -> sb_label_rdy pulse with 0x100. After buffer data, resp_vld=1 with resp_hit=0. Next cycle sb_label_rdy pulses with 0x101.
- After the above completes, miss 0x101 -> resp_vld 1 cycle later, resp_hit=1, resp_data = buffered line, then a prefetch of 0x102.
- Miss 0x101 issued while the 0x101 prefetch is in flight -> no new sb_label_rdy. resp_hit=0 when the prefetch lands.
- Miss 0x200 while the 0x101 prefetch is in flight -> DRAIN until sb_data_vld, then demand 0x200. resp_data is the 0x200 line, never the 0x101 line.
- Miss label 0x7FFFFFF (all ones) -> the follow-up prefetch label is 0x0000000.
- rst_n low mid-DWAIT -> all outputs 0 immediately. After release, a miss 0x300 runs the full demand sequence correctly. With SB_PERF_CNT_EN, the counters read 0/1/0 after one cold miss.
